// File: rtl/clk_div_prog_pkg.sv
// Shared constants and helpers for the programmable clock divider family.
// Divisor clamping and the high-phase length live here so every divider variant agrees on them.
package clk_div_prog_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned clamp_div(input int unsigned v);
        return (v < MIN_DIV) ? MIN_DIV : v;
    endfunction

    // Odd divisors put the extra cycle in the high phase.
    function automatic int unsigned high_len(input int unsigned n);
        return n - (n / 2);
    endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Phase counter for one divider channel: counts 0..N-1, flags the wrap edge,
// and re-arms to (N-1) while idle so the first enabled edge starts a fresh period.
module clk_div_phase #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_CNT = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] n_cur,
    input  logic [WIDTH-1:0] n_next,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign wrap = (cnt == (n_cur - ONE));

    // n_next is the divisor in force after this edge, so an idle re-arm already sees a newly applied value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= RESET_CNT;
        end else if (!en) begin
            cnt <= n_next - ONE;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: shadowed divisor, registered clk_out and a
// tick strobe at each period start. New divisors take effect only on a period boundary.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_pend,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(clamp_div(int'(DEFAULT_DIV)));
    localparam logic [WIDTH-1:0] RESET_CNT = RESET_DIV - WIDTH'(1);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] clamped_val;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   cnt_inc;
    logic             wrap;
    logic             apply;
    logic             next_high;

    // A pending shadow is applied on the wrap edge while running, or on any idle edge.
    assign apply       = div_pend && (!en || wrap);
    assign div_next    = apply ? shadow : div_cur;
    assign clamped_val = WIDTH'(clamp_div(32'(div_val)));
    assign high        = WIDTH'(high_len(32'(div_cur)));
    assign cnt_inc     = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign next_high   = (cnt_inc < {1'b0, high});

    clk_div_phase #(
        .WIDTH     (WIDTH),
        .RESET_CNT (RESET_CNT)
    ) u_phase (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .n_cur  (div_cur),
        .n_next (div_next),
        .cnt    (cnt),
        .wrap   (wrap)
    );

    // A load coinciding with an apply still lands in the shadow, so pending stays set.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cur  <= RESET_DIV;
            shadow   <= RESET_DIV;
            div_pend <= 1'b0;
        end else begin
            div_cur <= div_next;
            if (div_load) begin
                shadow   <= clamped_val;
                div_pend <= 1'b1;
            end else if (apply) begin
                div_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (wrap) begin
            clk_out <= 1'b1;
            tick    <= 1'b1;
        end else begin
            clk_out <= next_high;
            tick    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed, table-driven bench for clk_div_prog with hand-computed expected outputs
// per clock edge, plus a hand-written asynchronous clear sequence.
module tb_clk_div_prog;

    typedef struct {
        logic       en;
        logic       load;
        logic [7:0] val;
        logic       exp_clk;
        logic       exp_tick;
        logic       exp_pend;
        logic [7:0] exp_cur;
    } vec_t;

    logic       clk;
    logic       clr;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_pend;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_cur;

    int   checks;
    int   errors;
    vec_t vecs[$];

    clk_div_prog #(
        .WIDTH       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_pend (div_pend),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_cur  (div_cur)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic e, input logic l, input logic [7:0] v,
                                input logic c, input logic t, input logic p, input logic [7:0] cur);
        vec_t r;
        r.en = e; r.load = l; r.val = v;
        r.exp_clk = c; r.exp_tick = t; r.exp_pend = p; r.exp_cur = cur;
        vecs.push_back(r);
    endfunction

    task automatic check_output(input string name, input logic c, input logic t,
                                input logic p, input logic [7:0] cur);
        checks++;
        if ({clk_out, tick, div_pend, div_cur} !== {c, t, p, cur}) begin
            errors++;
            $display("[TB] FAIL %s: got clk_out=%b tick=%b div_pend=%b div_cur=%0d, want clk_out=%b tick=%b div_pend=%b div_cur=%0d",
                     name, clk_out, tick, div_pend, div_cur, c, t, p, cur);
        end
    endtask

    // Drive one edge's inputs, let the edge happen, then sample 1 time unit later.
    task automatic apply_stimulus(input logic e, input logic l, input logic [7:0] v);
        en       = e;
        div_load = l;
        div_val  = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clr      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;

        #2;
        check_output("reset_state", 1'b0, 1'b0, 1'b0, 8'd4);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // default N=4: 1,1,0,0 with tick on first enabled edge
        add(1,0,0, 1,1,0,4); add(1,0,0, 1,0,0,4); add(1,0,0, 0,0,0,4); add(1,0,0, 0,0,0,4);
        add(1,0,0, 1,1,0,4); add(1,0,0, 1,0,0,4);
        // load 5 at cnt=1, applied at the next wrap
        add(1,1,5, 0,0,1,4); add(1,0,0, 0,0,1,4); add(1,0,0, 1,1,0,5);
        add(1,0,0, 1,0,0,5); add(1,0,0, 1,0,0,5); add(1,0,0, 0,0,0,5); add(1,0,0, 0,0,0,5);
        add(1,0,0, 1,1,0,5);
        // loads of 0 and 1 clamp to 2
        add(1,1,0, 1,0,1,5); add(1,1,1, 1,0,1,5); add(1,0,0, 0,0,1,5); add(1,0,0, 0,0,1,5);
        add(1,0,0, 1,1,0,2); add(1,0,0, 0,0,0,2); add(1,0,0, 1,1,0,2); add(1,0,0, 0,0,0,2);
        // 7 then 9 back to back: only 9 ever reaches div_cur
        add(1,1,7, 1,1,1,2); add(1,1,9, 0,0,1,2); add(1,0,0, 1,1,0,9);
        add(1,0,0, 1,0,0,9); add(1,0,0, 1,0,0,9); add(1,0,0, 1,0,0,9); add(1,0,0, 1,0,0,9);
        add(1,0,0, 0,0,0,9); add(1,0,0, 0,0,0,9); add(1,0,0, 0,0,0,9); add(1,0,0, 0,0,0,9);
        add(1,0,0, 1,1,0,9);
        // shadow 3 pending, load 6 on the wrap edge: 3 applied, 6 next
        add(1,1,3, 1,0,1,9); add(1,0,0, 1,0,1,9); add(1,0,0, 1,0,1,9); add(1,0,0, 1,0,1,9);
        add(1,0,0, 0,0,1,9); add(1,0,0, 0,0,1,9); add(1,0,0, 0,0,1,9); add(1,0,0, 0,0,1,9);
        add(1,1,6, 1,1,1,3); add(1,0,0, 1,0,1,3); add(1,0,0, 0,0,1,3); add(1,0,0, 1,1,0,6);
        // en drop mid-period applies pending 8 and re-arms
        add(1,1,8, 1,0,1,6); add(0,0,0, 0,0,0,8); add(1,0,0, 1,1,0,8); add(1,0,0, 1,0,0,8);
        add(1,1,3, 1,0,1,8);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].en, vecs[i].load, vecs[i].val);
            check_output($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_tick,
                         vecs[i].exp_pend, vecs[i].exp_cur);
        end

        // async clear mid-high-phase (N=8, shadow 3 pending)
        div_load = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check_output("async_clr", 1'b0, 1'b0, 1'b0, 8'd4);
        #2;
        clr = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'd0);
        check_output("after_clr_idle", 1'b0, 1'b0, 1'b0, 8'd4);
        apply_stimulus(1'b1, 1'b0, 8'd0);
        check_output("restart_tick", 1'b1, 1'b1, 1'b0, 8'd4);
        apply_stimulus(1'b1, 1'b0, 8'd0);
        check_output("restart_cnt1", 1'b1, 1'b0, 1'b0, 8'd4);
        apply_stimulus(1'b1, 1'b0, 8'd0);
        check_output("restart_cnt2", 1'b0, 1'b0, 1'b0, 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
